// File: rtl/line_fill_responder.sv
// -----------------------------------------------------------------------------
// line_fill_responder
//
// Memory-side responder for a cache line-fill port. It holds a word-addressed
// storage array and serves two kinds of request:
//   * single-word write-through, committed at the accepting edge and
//     acknowledged with a one-cycle wr_done pulse; and
//   * read, either one word or a full line returned critical-word-first,
//     with the first beat appearing a fixed READ_LATENCY cycles after accept.
// Misaligned requests (byte address not a multiple of 4) are rejected with
// resp_err: a write is dropped, and a read returns a single zero beat.
//
// Ports
//   clk         in   sole clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   req_valid   in   request present
//   req_ready   out  responder can accept a request (IDLE only)
//   req_we      in   1 = write, 0 = read
//   req_burst   in   1 = full-line read, 0 = single-word read
//   req_addr    in   byte address
//   req_w_data  in   write data
//   resp_valid  out  read beat present
//   resp_ready  in   requester accepts beat
//   resp_data   out  read word
//   resp_addr   out  word-aligned byte address of resp_data
//   resp_last   out  final beat of the transaction
//   resp_err    out  transaction rejected (misaligned)
//   wr_done     out  one-cycle pulse, write committed
// -----------------------------------------------------------------------------
module line_fill_responder #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int LINE_WORDS   = 4,
  parameter int DEPTH_WORDS  = 1024,
  parameter int READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_burst,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_w_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic                  resp_last,
  output logic                  resp_err,
  output logic                  wr_done
);

  // Line offset width; the critical-word-first wrap relies on LINE_WORDS >= 2.
  localparam int LINE_AW    = $clog2(LINE_WORDS);
  localparam int DEPTH_AW   = $clog2(DEPTH_WORDS);
  localparam int WADDR_W    = ADDR_WIDTH - 2;
  localparam int LINE_NUM_W = WADDR_W - LINE_AW;
  localparam int LAT_W      = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LAT   = 2'd1,
    BURST = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  // Control registers (reset)
  logic [LAT_W-1:0]        r_lat;
  logic [LINE_AW-1:0]      r_beat;
  logic                    r_burst;
  logic                    r_rd_err;
  logic                    r_wr_done;
  logic                    r_wr_err;

  // Datapath registers (not reset; outputs are gated by state instead)
  logic [LINE_NUM_W-1:0]   r_line;
  logic [LINE_AW-1:0]      r_start;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [DATA_WIDTH-1:0]   r_mem [DEPTH_WORDS];

  logic                    w_accept;
  logic                    w_misal;
  logic                    w_wr_commit;
  logic                    w_rd_accept;
  logic                    w_lat_done;
  logic                    w_last;
  logic                    w_beat_hs;
  logic                    w_load_first;
  logic                    w_load_next;
  logic [LINE_AW-1:0]      w_word;
  logic [LINE_AW-1:0]      w_rd_word;
  logic [WADDR_W-1:0]      w_rd_waddr;
  logic [DEPTH_AW-1:0]     w_rd_idx;
  logic [DEPTH_AW-1:0]     w_wr_idx;

  assign w_accept    = req_valid & req_ready;
  assign w_misal     = (req_addr[1:0] != 2'b00);
  assign w_wr_commit = w_accept & req_we & ~w_misal;
  assign w_rd_accept = w_accept & ~req_we;

  // Higher address bits alias onto the same storage word.
  assign w_wr_idx    = req_addr[DEPTH_AW+1:2];

  assign w_lat_done  = (r_lat == '0);

  // Critical-word-first: the offset wraps naturally at the line boundary.
  assign w_word      = r_start + r_beat;
  assign w_last      = ~r_burst | (r_beat == LINE_AW'(LINE_WORDS - 1));
  assign w_beat_hs   = (r_state == BURST) & resp_ready;

  // The output word register is filled one edge ahead of the beat it serves:
  // on leaving LAT for the first beat, on each non-final handshake for the next.
  assign w_load_first = (r_state == LAT) & w_lat_done;
  assign w_load_next  = w_beat_hs & ~w_last;
  assign w_rd_word    = w_load_first ? r_start : (w_word + LINE_AW'(1));
  assign w_rd_waddr   = {r_line, w_rd_word};
  assign w_rd_idx     = DEPTH_AW'(w_rd_waddr);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and outputs
  always_comb begin
    w_state_nxt = r_state;
    req_ready   = 1'b0;
    resp_valid  = 1'b0;
    resp_last   = 1'b0;
    resp_err    = r_wr_err;
    resp_data   = '0;
    resp_addr   = '0;
    wr_done     = r_wr_done;
    unique case (r_state)
      IDLE: begin
        // rst_n gating keeps req_ready low while reset is held.
        req_ready = rst_n;
        if (w_rd_accept) begin
          w_state_nxt = LAT;
        end
      end
      LAT: begin
        if (w_lat_done) begin
          w_state_nxt = BURST;
        end
      end
      BURST: begin
        resp_valid = 1'b1;
        resp_last  = w_last;
        resp_err   = r_rd_err;
        resp_data  = r_rd_err ? '0 : r_data;
        resp_addr  = {r_line, w_word, 2'b00};
        if (resp_ready && w_last) begin
          w_state_nxt = IDLE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Control counters and flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lat     <= '0;
      r_beat    <= '0;
      r_burst   <= 1'b0;
      r_rd_err  <= 1'b0;
      r_wr_done <= 1'b0;
      r_wr_err  <= 1'b0;
    end else begin
      r_wr_done <= w_wr_commit;
      r_wr_err  <= w_accept & req_we & w_misal;
      if (w_rd_accept) begin
        r_lat    <= LAT_W'(READ_LATENCY - 1);
        r_beat   <= '0;
        // A rejected read always collapses to one beat.
        r_burst  <= req_burst & ~w_misal;
        r_rd_err <= w_misal;
      end else begin
        if ((r_state == LAT) && !w_lat_done) begin
          r_lat <= r_lat - LAT_W'(1);
        end
        if (w_load_next) begin
          r_beat <= r_beat + LINE_AW'(1);
        end
      end
    end
  end

  // Storage and read-side datapath; storage contents survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_commit) begin
      r_mem[w_wr_idx] <= req_w_data;
    end
    if (w_rd_accept) begin
      r_line  <= req_addr[ADDR_WIDTH-1:LINE_AW+2];
      r_start <= req_addr[LINE_AW+1:2];
    end
    if (w_load_first || w_load_next) begin
      r_data <= r_mem[w_rd_idx];
    end
  end

endmodule
